// File: rtl/sram_serial_bridge.sv
// Serial command bridge to a synchronous SRAM: header (op, addr, len), then write or read bursts.
// Latency: header HDR_WIDTH cycles; DATA_WIDTH+1 cycles per written word, DATA_WIDTH+2 per read word.
// No backpressure: LOAD_N paces the transaction, and raising it early aborts back to IDLE.
module sram_serial_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD_N,
    input  logic                  SI,
    input  logic [DATA_WIDTH-1:0] PI,
    output logic                  RDY,
    output logic                  BUSY,
    output logic                  CEN,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] PO,
    output logic                  SO,
    output logic                  SO_VLD
);

    localparam int HDR_WIDTH = 1 + ADDR_WIDTH + LEN_WIDTH;
    localparam int CNT_MAX   = (HDR_WIDTH > DATA_WIDTH) ? HDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W     = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        IDLE, HDR, WDAT, WR, RREQ, RCAP, RSHF, DONE
    } state_t;

    state_t                  state;
    logic [HDR_WIDTH-2:0]    hdr_sr;
    logic [HDR_WIDTH-1:0]    hdr_nxt;
    logic [CNT_W-1:0]        bit_cnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [LEN_WIDTH-1:0]    wcnt;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic                    last_word;
    logic                    bit_last;
    logic                    abort;

    // Full header including the bit arriving this cycle, so decode happens on the last edge.
    assign hdr_nxt   = {SI, hdr_sr};
    assign last_word = (wcnt == '0);
    assign bit_last  = (bit_cnt == '0);
    assign abort     = LOAD_N && (state != IDLE) && (state != DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            hdr_sr  <= '0;
            bit_cnt <= '0;
            addr    <= '0;
            wcnt    <= '0;
            data_sr <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!LOAD_N) begin
                        state   <= HDR;
                        bit_cnt <= CNT_W'(HDR_WIDTH - 1);
                    end
                end
                HDR: begin
                    hdr_sr <= hdr_nxt[HDR_WIDTH-1:1];
                    if (bit_last) begin
                        addr    <= hdr_nxt[ADDR_WIDTH:1];
                        wcnt    <= hdr_nxt[HDR_WIDTH-1:ADDR_WIDTH+1];
                        bit_cnt <= CNT_W'(DATA_WIDTH - 1);
                        state   <= hdr_nxt[0] ? RREQ : WDAT;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                WDAT: begin
                    data_sr <= {SI, data_sr[DATA_WIDTH-1:1]};
                    if (bit_last) begin
                        state <= WR;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                WR: begin
                    if (last_word) begin
                        state <= DONE;
                    end else begin
                        addr    <= addr + 1'b1;
                        wcnt    <= wcnt - 1'b1;
                        bit_cnt <= CNT_W'(DATA_WIDTH - 1);
                        state   <= WDAT;
                    end
                end
                RREQ: state <= RCAP;
                RCAP: begin
                    data_sr <= PI;
                    bit_cnt <= CNT_W'(DATA_WIDTH - 1);
                    state   <= RSHF;
                end
                RSHF: begin
                    data_sr <= data_sr >> 1;
                    if (!bit_last) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (last_word) begin
                        state <= DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        wcnt  <= wcnt - 1'b1;
                        state <= RREQ;
                    end
                end
                DONE: begin
                    if (LOAD_N) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so no input-to-output combinational paths.
    assign RDY    = (state == DONE);
    assign BUSY   = (state != IDLE) && (state != DONE);
    assign CEN    = (state == WR) || (state == RREQ);
    assign WE     = (state == WR);
    assign A      = CEN ? addr : '0;
    assign PO     = WE ? data_sr : '0;
    assign SO_VLD = (state == RSHF);
    assign SO     = SO_VLD ? data_sr[0] : 1'b0;

endmodule

// File: tb/tb_sram_serial_bridge.sv
// Scoreboard bench for sram_serial_bridge with a synchronous SRAM model on A/PO/PI.
module tb_sram_serial_bridge;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LOAD_N = 1'b1;
    logic       SI = 1'b0;
    logic [7:0] PI;
    logic       RDY, BUSY, CEN, WE, SO, SO_VLD;
    logic [8:0] A;
    logic [7:0] PO;

    always #5 CLK = ~CLK;

    sram_serial_bridge dut (
        .CLK(CLK), .RST(RST), .LOAD_N(LOAD_N), .SI(SI), .PI(PI),
        .RDY(RDY), .BUSY(BUSY), .CEN(CEN), .WE(WE), .A(A), .PO(PO),
        .SO(SO), .SO_VLD(SO_VLD)
    );

    bit [7:0] mem [512];
    bit [7:0] ref_mem [512];

    always @(posedge CLK) begin
        if (CEN && WE) mem[A] <= PO;
        PI <= (CEN && !WE) ? mem[A] : 8'h00;
    end

    typedef struct { logic [8:0] a; logic [7:0] d; int c; } wr_t;
    typedef struct { logic b; int c; } so_t;
    wr_t wr_q[$];
    so_t so_q[$];

    int cyc = 0;
    int t0 = 0;
    int n_cmp = 0;
    int n_err = 0;
    int we_total = 0;
    bit [7:0] wdata [16];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc - t0);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT writes SRAM or shifts out a bit.
    initial begin : mon
        wr_t ew;
        so_t es;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (CEN && WE) begin
                    we_total++;
                    if (wr_q.size() == 0) begin
                        chk("wr_unexpected", {23'b0, A}, 32'hFFFF_FFFF);
                    end else begin
                        ew = wr_q.pop_front();
                        chk("wr_addr", {23'b0, A}, {23'b0, ew.a});
                        chk("wr_data", {24'b0, PO}, {24'b0, ew.d});
                        chk("wr_cycle", cyc, ew.c);
                    end
                end
                if (SO_VLD) begin
                    if (so_q.size() == 0) begin
                        chk("so_unexpected", {31'b0, SO}, 32'hFFFF_FFFF);
                    end else begin
                        es = so_q.pop_front();
                        chk("so_bit", {31'b0, SO}, {31'b0, es.b});
                        chk("so_cycle", cyc, es.c);
                    end
                end else begin
                    chk("so_idle", {31'b0, SO}, 0);
                end
                if (!CEN) chk("bus_idle", {15'b0, A, PO}, 0);
            end
        end
    end

    // One transaction; abort_w >= 0 raises LOAD_N during bit 3 of that write word.
    task automatic txn(input bit op, input logic [8:0] addr, input logic [3:0] len, input int abort_w);
        logic [13:0] hdr;
        logic [8:0]  wa;
        int          nw;
        hdr = {len, addr, op};
        nw  = int'(len) + 1;
        @(negedge CLK);
        LOAD_N = 1'b0;
        SI     = 1'b0;
        t0     = cyc;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            SI = hdr[i];
        end
        for (int w = 0; w < nw; w++) begin
            wa = addr + 9'(w);
            if (!op) begin
                for (int b = 0; b < 8; b++) begin
                    @(negedge CLK);
                    if (w == abort_w && b == 3) begin
                        chk("abort_busy_before", {31'b0, BUSY}, 1);
                        LOAD_N = 1'b1;
                        @(negedge CLK);
                        chk("abort_busy_after", {31'b0, BUSY}, 0);
                        chk("abort_rdy", {31'b0, RDY}, 0);
                        repeat (12) @(negedge CLK);
                        chk("abort_rdy_late", {31'b0, RDY}, 0);
                        return;
                    end
                    SI = wdata[w][b];
                end
                wr_q.push_back('{a: wa, d: wdata[w], c: t0 + 14 + (w + 1) * 9});
                ref_mem[wa] = wdata[w];
                @(negedge CLK);
                SI = 1'($urandom);
            end else begin
                for (int b = 0; b < 8; b++)
                    so_q.push_back('{b: ref_mem[wa][b], c: t0 + 14 + w * 10 + 3 + b});
                SI = 1'b0;
                repeat (10) @(negedge CLK);
            end
        end
        chk("rdy_before", {31'b0, RDY}, 0);
        chk("busy_run", {31'b0, BUSY}, 1);
        @(negedge CLK);
        chk("rdy_cycle", {31'b0, RDY}, 1);
        chk("busy_done", {31'b0, BUSY}, 0);
        repeat (3) @(negedge CLK);
        chk("rdy_hold", {31'b0, RDY}, 1);
        chk("no_restart", {31'b0, BUSY}, 0);
        LOAD_N = 1'b1;
        @(negedge CLK);
        chk("rdy_clear", {31'b0, RDY}, 0);
    endtask

    initial begin
        int we_base;
        logic [8:0] ra;
        logic [3:0] rl;

        #1;
        chk("reset_outputs", {8'b0, RDY, BUSY, CEN, WE, A, PO, SO, SO_VLD}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Reset mid-header, then a fresh transaction must decode cleanly.
        LOAD_N = 1'b0;
        t0 = cyc;
        repeat (5) begin
            @(negedge CLK);
            SI = 1'b1;
        end
        chk("hdr_busy", {31'b0, BUSY}, 1);
        RST = 1'b1;
        #1;
        chk("rst_mid_hdr", {8'b0, RDY, BUSY, CEN, WE, A, PO, SO, SO_VLD}, 0);
        LOAD_N = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_after_rst", {31'b0, BUSY}, 0);

        wdata[0] = 8'hC3;
        txn(1'b0, 9'h05A, 4'd0, -1);

        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
        we_base = we_total;
        txn(1'b0, 9'h1FE, 4'd2, -1);
        chk("wrap_we_count", we_total - we_base, 3);

        wdata[0] = 8'hA5; wdata[1] = 8'h3C;
        txn(1'b0, 9'h010, 4'd1, -1);
        txn(1'b1, 9'h010, 4'd1, -1);

        for (int i = 0; i < 4; i++) wdata[i] = 8'($urandom);
        txn(1'b0, 9'h100, 4'd3, 1);
        chk("abort_no_extra_wr", wr_q.size(), 0);
        txn(1'b1, 9'h100, 4'd1, -1);
        txn(1'b1, 9'h1FF, 4'd1, -1);

        for (int k = 0; k < 3; k++) begin
            ra = 9'($urandom);
            rl = 4'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
            txn(1'b0, ra, rl, -1);
            txn(1'b1, ra - 9'd1, rl + 4'd1, -1);
        end

        repeat (4) @(negedge CLK);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("so_q_drained", so_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
